// File: rtl/multicycle_control_pkg.sv
// Shared types and constants for the multicycle MIPS control FSM:
// state encodings, opcode/funct fields, ALU codes and datapath select values.
package multicycle_pkg;

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    ALUWB  = 4'd7,
    BRANCH = 4'd8,
    JUMP   = 4'd9,
    ADDIEX = 4'd10,
    ADDIWB = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/multicycle_control_if.sv
// Control bundle between the instruction register / memory handshake and the
// multicycle datapath. master = control FSM, slave = datapath side.
interface multicycle_control_if #(
  parameter int ALUCTRL_W = 3
);
  logic [5:0]           opcode;
  logic [5:0]           funct;
  logic                 mem_ready;
  logic                 iord;
  logic                 mem_read;
  logic                 mem_write;
  logic                 ir_write;
  logic                 reg_dst;
  logic                 mem_to_reg;
  logic                 reg_write;
  logic                 alu_src_a;
  logic [1:0]           alu_src_b;
  logic [ALUCTRL_W-1:0] alu_control;
  logic [1:0]           pc_src;
  logic                 pc_write;
  logic                 beq;
  logic                 bne;
  logic                 illegal_op;
  logic                 mem_timeout;
  logic [3:0]           state;

  modport master (
    input  opcode, funct, mem_ready,
    output iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
           reg_write, alu_src_a, alu_src_b, alu_control, pc_src,
           pc_write, beq, bne, illegal_op, mem_timeout, state
  );

  modport slave (
    output opcode, funct, mem_ready,
    input  iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
           reg_write, alu_src_a, alu_src_b, alu_control, pc_src,
           pc_write, beq, bne, illegal_op, mem_timeout, state
  );
endinterface

// File: rtl/multicycle_control_alu_decoder.sv
// R-type funct field to ALU operation; funct_valid flags the supported subset.
module alu_decoder
  import multicycle_pkg::*;
(
  input  logic [5:0] funct,
  output logic [2:0] alu_control,
  output logic       funct_valid
);

  always_comb begin
    alu_control = ALU_ADD;
    funct_valid = 1'b1;
    case (funct)
      FN_ADD:  alu_control = ALU_ADD;
      FN_SUB:  alu_control = ALU_SUB;
      FN_AND:  alu_control = ALU_AND;
      FN_OR:   alu_control = ALU_OR;
      FN_SLT:  alu_control = ALU_SLT;
      default: funct_valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Moore control FSM for the multicycle MIPS datapath with mem_ready wait,
// wait-timeout watchdog and illegal-instruction flag. ADDI support is enabled
// by defining MULTICYCLE_CONTROL_ADDI_EN.
module multicycle_control
  import multicycle_pkg::*;
#(
  parameter int ALUCTRL_W     = 3,
  parameter bit MEM_HANDSHAKE = 1'b1,
  parameter int WAIT_TIMEOUT  = 16,
  parameter int WAIT_CNT_W    = (WAIT_TIMEOUT > 0) ? $clog2(WAIT_TIMEOUT + 1) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  multicycle_control_if.master bus
);

  localparam logic [WAIT_CNT_W-1:0] CNT_MAX = WAIT_CNT_W'(WAIT_TIMEOUT);
`ifdef MULTICYCLE_CONTROL_ADDI_EN
  localparam state_t LAST_STATE = ADDIWB;
`else
  localparam state_t LAST_STATE = JUMP;
`endif

  state_t                state_reg;
  state_t                state_next;
  logic [WAIT_CNT_W-1:0] wait_cnt_reg;
  logic                  ready;
  logic                  fetch_like;
  logic                  wait_state;
  logic                  timeout;
  logic [2:0]            dec_alu;
  logic                  dec_valid;

  alu_decoder u_alu_decoder (
    .funct       (bus.funct),
    .alu_control (dec_alu),
    .funct_valid (dec_valid)
  );

  // Encodings beyond the last implemented state behave exactly like FETCH.
  assign fetch_like = (state_reg == FETCH) || (state_reg > LAST_STATE);
  assign ready      = MEM_HANDSHAKE ? bus.mem_ready : 1'b1;
  assign wait_state = fetch_like || (state_reg == MEMRD) || (state_reg == MEMWR);
  assign timeout    = (WAIT_TIMEOUT > 0) && wait_state && !ready && (wait_cnt_reg == CNT_MAX);
  assign bus.state  = state_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= FETCH;
      wait_cnt_reg <= '0;
    end else begin
      state_reg <= state_next;
      // A timeout re-enters FETCH without a state change, so clear explicitly.
      if ((state_next != state_reg) || timeout)
        wait_cnt_reg <= '0;
      else if (wait_state && !ready && (wait_cnt_reg != CNT_MAX))
        wait_cnt_reg <= wait_cnt_reg + WAIT_CNT_W'(1);
    end
  end

  always_comb begin
    state_next      = state_reg;
    bus.iord        = 1'b0;
    bus.mem_read    = 1'b0;
    bus.mem_write   = 1'b0;
    bus.ir_write    = 1'b0;
    bus.reg_dst     = 1'b0;
    bus.mem_to_reg  = 1'b0;
    bus.reg_write   = 1'b0;
    bus.alu_src_a   = 1'b0;
    bus.alu_src_b   = SRCB_B;
    bus.alu_control = ALUCTRL_W'(ALU_ADD);
    bus.pc_src      = PCSRC_ALU;
    bus.pc_write    = 1'b0;
    bus.beq         = 1'b0;
    bus.bne         = 1'b0;
    bus.illegal_op  = 1'b0;
    bus.mem_timeout = 1'b0;

    if (!reset) begin
      case (state_reg)
        DECODE: begin
          bus.alu_src_b = SRCB_IMM_SH;
          case (bus.opcode)
            OP_RTYPE:       state_next = EXEC;
            OP_LW, OP_SW:   state_next = MEMADR;
            OP_BEQ, OP_BNE: state_next = BRANCH;
            OP_J:           state_next = JUMP;
`ifdef MULTICYCLE_CONTROL_ADDI_EN
            OP_ADDI:        state_next = ADDIEX;
`endif
            default: begin
              bus.illegal_op = 1'b1;
              state_next     = FETCH;
            end
          endcase
        end
        MEMADR: begin
          bus.alu_src_a = 1'b1;
          bus.alu_src_b = SRCB_IMM;
          if (bus.opcode == OP_SW)
            state_next = MEMWR;
          else if (bus.opcode == OP_LW)
            state_next = MEMRD;
          else
            state_next = FETCH;
        end
        MEMRD: begin
          bus.iord     = 1'b1;
          bus.mem_read = 1'b1;
          if (ready) begin
            state_next = MEMWB;
          end else if (timeout) begin
            bus.mem_timeout = 1'b1;
            state_next      = FETCH;
          end
        end
        MEMWB: begin
          bus.reg_write  = 1'b1;
          bus.mem_to_reg = 1'b1;
          state_next     = FETCH;
        end
        MEMWR: begin
          bus.iord      = 1'b1;
          bus.mem_write = !timeout;
          if (ready) begin
            state_next = FETCH;
          end else if (timeout) begin
            bus.mem_timeout = 1'b1;
            state_next      = FETCH;
          end
        end
        EXEC: begin
          bus.alu_src_a = 1'b1;
          if (dec_valid) begin
            bus.alu_control = ALUCTRL_W'(dec_alu);
            state_next      = ALUWB;
          end else begin
            bus.illegal_op = 1'b1;
            state_next     = FETCH;
          end
        end
        ALUWB: begin
          bus.reg_write = 1'b1;
          bus.reg_dst   = 1'b1;
          state_next    = FETCH;
        end
        BRANCH: begin
          bus.alu_src_a   = 1'b1;
          bus.alu_control = ALUCTRL_W'(ALU_SUB);
          bus.pc_src      = PCSRC_ALUOUT;
          bus.beq         = (bus.opcode == OP_BEQ);
          bus.bne         = (bus.opcode == OP_BNE);
          state_next      = FETCH;
        end
        JUMP: begin
          bus.pc_src   = PCSRC_JUMP;
          bus.pc_write = 1'b1;
          state_next   = FETCH;
        end
`ifdef MULTICYCLE_CONTROL_ADDI_EN
        ADDIEX: begin
          bus.alu_src_a = 1'b1;
          bus.alu_src_b = SRCB_IMM;
          state_next    = ADDIWB;
        end
        ADDIWB: begin
          bus.reg_write = 1'b1;
          state_next    = FETCH;
        end
`endif
        default: begin
          // FETCH and any unimplemented encoding
          bus.mem_read  = 1'b1;
          bus.alu_src_b = SRCB_FOUR;
          if (ready) begin
            bus.ir_write = 1'b1;
            bus.pc_write = 1'b1;
            state_next   = DECODE;
          end else if (timeout) begin
            bus.mem_timeout = 1'b1;
            state_next      = FETCH;
          end else begin
            state_next = FETCH;
          end
        end
      endcase
    end
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Moore-style control FSM for the multicycle MIPS datapath; successor to the single-cycle opcode/funct decoder.
- Sequences one instruction over 3–5 states on a shared memory port and shared ALU.
- Adds a mem_ready wait handshake, a wait-timeout watchdog and illegal-instruction flagging.
- Sits between the instruction register (opcode/funct) and the datapath mux/enable inputs.

Parameters:
- ALUCTRL_W, 3, width of alu_control.
- MEM_HANDSHAKE, 1: 1 = memory states wait for mem_ready; 0 = mem_ready ignored, memory completes in one cycle.
- WAIT_TIMEOUT, 16: maximum consecutive stalled cycles in one memory state before abort; 0 disables the watchdog.
- WAIT_CNT_W, $clog2(WAIT_TIMEOUT+1) (minimum 1), width of the wait counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- opcode  in  6  instruction[31:26] from the IR.
- funct  in  6  instruction[5:0] from the IR.
- mem_ready  in  1  memory has completed the current access.
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- ir_write  out  1  IR load enable.
- reg_dst  out  1  write-register select: 1 = rd, 0 = rt.
- mem_to_reg  out  1  write-back select: 1 = MDR, 0 = ALUOut.
- reg_write  out  1  register file write enable.
- alu_src_a  out  1  ALU A select: 0 = PC, 1 = reg A.
- alu_src_b  out  2  ALU B select: 00 = B, 01 = constant 4, 10 = sign-extended imm, 11 = sign-extended imm << 2.
- alu_control  out  ALUCTRL_W  ALU operation.
- pc_src  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- pc_write  out  1  unconditional PC write.
- beq  out  1  conditional PC write on zero.
- bne  out  1  conditional PC write on not-zero.
- illegal_op  out  1  one-cycle pulse on an unsupported opcode or funct.
- mem_timeout  out  1  one-cycle pulse when the watchdog aborts a memory access.
- state  out  4  current state encoding, for debug.

Behaviour:
- States:
  - FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, JUMP=9, ADDIEX=10, ADDIWB=11.
- Reset:
  - state=FETCH, wait counter=0.
  - While reset is high, every enable/request output is 0, alu_control=010, all select outputs are 0, and both pulse outputs are 0.
- All outputs are decoded combinationally from the registered state, plus mem_ready/counter where noted. Unlisted outputs are 0.
- FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_control=010. ir_write=pc_write=1 only in the cycle mem_ready=1 (always 1 if MEM_HANDSHAKE=0); advance to DECODE that cycle.
- DECODE: alu_src_a=0, alu_src_b=11, alu_control=010. Next state by opcode:
  - 000000 → EXEC
  - 100011/101011 → MEMADR
  - 000100/000101 → BRANCH
  - 000010 → JUMP
  - 001000 → ADDIEX (macro only)
  - other → FETCH with illegal_op=1.
- MEMADR: alu_src_a=1, alu_src_b=10, alu_control=010. lw → MEMRD; sw → MEMWR.
- MEMRD: mem_read=1, iord=1. Advance to MEMWB on mem_ready.
- MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0. Then FETCH.
- MEMWR: mem_write=1, iord=1. Advance to FETCH on mem_ready.
- EXEC: alu_src_a=1, alu_src_b=00, alu_control from funct:
  - 100000 → 010 (add)
  - 100010 → 110 (sub)
  - 100100 → 000 (and)
  - 100101 → 001 (or)
  - 101010 → 111 (slt)
  - Unknown funct: alu_control=010, illegal_op=1, next state FETCH (no write-back). Known funct: next state ALUWB.
- ALUWB: reg_write=1, reg_dst=1, mem_to_reg=0. Then FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_control=110, pc_src=01. beq=1 for opcode 000100, bne=1 for opcode 000101. Then FETCH.
- JUMP: pc_src=10, pc_write=1. Then FETCH.
- Cycle counts with zero wait: R-type 4, lw 5, sw 4, beq/bne/j 3.
- Wait counter:
  - Increments each cycle in FETCH/MEMRD/MEMWR with mem_ready=0.
  - Clears on any state change.
  - Saturates at WAIT_TIMEOUT.
- Timeout: when the counter equals WAIT_TIMEOUT (WAIT_TIMEOUT>0) and mem_ready=0, mem_timeout=1 for that cycle, ir_write/pc_write/mem_write are suppressed, and next state is FETCH.
- mem_ready=1 in the same cycle as the timeout: mem_ready wins and the access completes normally.
- An asynchronous reset mid-instruction aborts immediately. No partial write is retried.

Optional Feature:
- Macro: MULTICYCLE_CONTROL_ADDI_EN.
- Defined: opcode 001000 is supported via DECODE → ADDIEX → ADDIWB → FETCH.
  - ADDIEX: alu_src_a=1, alu_src_b=10, alu_control=010.
  - ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=0.
- Undefined: opcode 001000 is illegal. States 10/11 are unreachable and decode as FETCH.

Decomposition:
- Package multicycle_pkg holds:
  - state_t enum (4-bit, encodings above)
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_ADDI
  - funct constants
  - ALU codes ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT
  - alu_src_b and pc_src select constants
- Sub-module alu_decoder: combinational funct → {alu_control, funct_valid}, instantiated for EXEC.

Test Plan:
- Reset asserted mid-MEMRD → state=0 immediately, all enables 0. After release, FETCH issues mem_read=1.
- add (op 000000, funct 100000), mem_ready tied 1 → states 0,1,6,7; alu_control=010 in EXEC; reg_write=1 and reg_dst=1 in cycle 4.
- lw, mem_ready low 3 cycles in MEMRD → states 0,1,2,3,3,3,3,4; reg_write=1 and mem_to_reg=1 only in MEMWB.
- bne (000101) → states 0,1,8; bne=1, beq=0, alu_control=110, pc_src=01 in BRANCH.
- FETCH with mem_ready held 0, WAIT_TIMEOUT=16 → mem_timeout pulse on the 17th FETCH cycle, ir_write never 1, state returns to FETCH.
- opcode 001000 → with macro defined: states 0,1,10,11 and reg_write=1 in ADDIWB. Without macro: illegal_op=1 in DECODE, next state 0.
